// File: rtl/instr_fetch_pkg.sv
// Shared constants and PC arithmetic for the instruction fetch unit.
// Bit 31 of every PC is the supervisor flag; bits [30:0] are the byte address.
package instr_fetch_pkg;

  localparam logic TRAP_ILLOP = 1'b0;
  localparam logic TRAP_XADR  = 1'b1;

  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_ILLOP_ADDR = 32'h0000_0004;
  localparam logic [31:0] DEFAULT_XADR_ADDR  = 32'h0000_0008;
  localparam int          DEFAULT_IMEM_WORDS = 128;

  // Address bits wrap modulo 2^31; the supervisor bit is carried over untouched.
  function automatic logic [31:0] pc_increment(input logic [31:0] cur);
    return {cur[31], cur[30:0] + 31'd4};
  endfunction

  // A redirect may drop supervisor mode but never grant it.
  function automatic logic [31:0] redirect_target(input logic [31:0] target,
                                                  input logic [31:0] cur);
    return {target[31] & cur[31], target[30:0]};
  endfunction

  function automatic logic [31:0] vector_target(input logic [31:0] vec);
    return {1'b1, vec[30:0]};
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, addresses the external ROM and registers
// the returned word into a valid/ready instruction register for decode.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
  parameter logic [31:0] ILLOP_ADDR = DEFAULT_ILLOP_ADDR,
  parameter logic [31:0] XADR_ADDR  = DEFAULT_XADR_ADDR,
  parameter int          IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] id,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  input  logic        trap_sel,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_fault
);

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

  logic [31:0] pc_q;
  logic [31:0] fetch_pc;
  logic        fault;
  logic        load;

  // Traps beat redirects; during reset the ROM is pointed at the reset vector.
  always_comb begin
    fetch_pc = pc_q;
    if (reset)
      fetch_pc = RESET_ADDR;
    else if (trap_valid)
      fetch_pc = vector_target((trap_sel == TRAP_XADR) ? XADR_ADDR : ILLOP_ADDR);
    else if (redirect_valid)
      fetch_pc = redirect_target(redirect_pc, pc_q);
  end

  assign pc    = {1'b0, fetch_pc[30:0]};
  assign fault = {1'b0, fetch_pc[30:0]} >= IMEM_BYTES;
  assign load  = trap_valid | redirect_valid | ~ir_valid | ir_ready;

  // A redirect or trap always loads, squashing any stalled younger instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_ADDR;
      ir_valid <= 1'b0;
      ir       <= 32'h0;
      ir_pc    <= 32'h0;
      ir_fault <= 1'b0;
    end else if (load) begin
      pc_q     <= pc_increment(fetch_pc);
      ir_valid <= 1'b1;
      ir       <= fault ? 32'h0 : id;
      ir_pc    <= fetch_pc;
      ir_fault <= fault;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vectors with literal expectations plus a
// per-cycle comparison against an arithmetic model of the fetch rules.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] id;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic        trap_sel;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_fault;

  int checks = 0;
  int errors = 0;
  bit compareOn = 1'b0;

  // Model state
  logic [31:0] mPcq;
  logic        mValid;
  logic [31:0] mIr;
  logic [31:0] mIrPc;
  logic        mFault;

  instr_fetch dut (
    .clk(clk), .reset(reset), .pc(pc), .id(id),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_sel(trap_sel),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir),
    .ir_pc(ir_pc), .ir_fault(ir_fault)
  );

  always #5 clk = ~clk;

  always_comb id = 32'hA500_0000 | pc;

  function automatic logic [31:0] modelFetch(input logic [31:0] cur);
    if (trap_valid)
      return 32'h8000_0000 | (trap_sel ? 32'h8 : 32'h4);
    if (redirect_valid)
      return (redirect_pc & 32'h7FFF_FFFF) | (redirect_pc & cur & 32'h8000_0000);
    return cur;
  endfunction

  always @(posedge clk) begin
    logic [31:0] f;
    if (reset) begin
      mPcq = 32'h0; mValid = 1'b0; mIr = 32'h0; mIrPc = 32'h0; mFault = 1'b0;
    end else if (trap_valid || redirect_valid || !mValid || ir_ready) begin
      f      = modelFetch(mPcq);
      mFault = (f & 32'h7FFF_FFFF) >= 32'd512;
      mIr    = mFault ? 32'h0 : (32'hA500_0000 | (f & 32'h7FFF_FFFF));
      mIrPc  = f;
      mValid = 1'b1;
      mPcq   = (f & 32'h8000_0000) | (((f & 32'h7FFF_FFFF) + 32'd4) & 32'h7FFF_FFFF);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, away from the active edge, the DUT must agree with the model.
  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("cyc_ir_valid", {31'h0, ir_valid}, {31'h0, mValid});
      checkOutput("cyc_ir", ir, mIr);
      checkOutput("cyc_ir_pc", ir_pc, mIrPc);
      checkOutput("cyc_ir_fault", {31'h0, ir_fault}, {31'h0, mFault});
      checkOutput("cyc_pc", pc, reset ? 32'h0 : (modelFetch(mPcq) & 32'h7FFF_FFFF));
    end
  end

  task automatic applyStimulus(input logic rst, input logic rdy, input logic rv,
                               input logic [31:0] rpc, input logic tv, input logic ts);
    reset = rst; ir_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    trap_valid = tv; trap_sel = ts;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ir_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    trap_valid = 1'b0; trap_sel = 1'b0;

    applyStimulus(1, 0, 0, 0, 0, 0);
    compareOn = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rst_valid", {31'h0, ir_valid}, 32'h0);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_ir", ir, 32'h0);

    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("first_valid", {31'h0, ir_valid}, 32'h1);
    checkOutput("first_ir", ir, 32'hA500_0000);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("seq_pc4", ir_pc, 32'h4);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("seq_pc8", ir_pc, 32'h8);

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("stall_ir_pc", ir_pc, 32'h8);
    checkOutput("stall_ir", ir, 32'hA500_0008);
    checkOutput("stall_pc", pc, 32'hC);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("unstall_pc", ir_pc, 32'hC);

    applyStimulus(0, 0, 1, 32'h64, 0, 0);
    checkOutput("redir_ir_pc", ir_pc, 32'h64);
    checkOutput("redir_ir", ir, 32'hA500_0064);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("redir_next", ir_pc, 32'h68);

    applyStimulus(0, 1, 1, 32'h64, 1, 1);
    checkOutput("trap_xadr", ir_pc, 32'h8000_0008);
    applyStimulus(0, 1, 1, 32'hDC, 0, 0);
    checkOutput("leave_super", ir_pc, 32'hDC);
    applyStimulus(0, 1, 1, 32'h8000_0010, 0, 0);
    checkOutput("no_enter_super", ir_pc, 32'h10);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("trap_illop", ir_pc, 32'h8000_0004);

    applyStimulus(0, 1, 1, 32'h1FC, 0, 0);
    checkOutput("last_word_fault", {31'h0, ir_fault}, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("oob_pc", ir_pc, 32'h200);
    checkOutput("oob_fault", {31'h0, ir_fault}, 32'h1);
    checkOutput("oob_ir", ir, 32'h0);

    applyStimulus(0, 1, 0, 0, 1, 0);
    applyStimulus(0, 1, 1, 32'hFFFF_FFF8, 0, 0);
    checkOutput("super_redir", ir_pc, 32'hFFFF_FFF8);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("pre_wrap", ir_pc, 32'hFFFF_FFFC);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("wrap_pc", ir_pc, 32'h8000_0000);
    checkOutput("wrap_ir", ir, 32'hA500_0000);

    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("midrst_valid", {31'h0, ir_valid}, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("restart_pc", ir_pc, 32'h0);
    checkOutput("restart_valid", {31'h0, ir_valid}, 32'h1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0, 0);

    compareOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
